// File: rtl/interlaken_seg_checker.sv
// interlaken_seg_checker
// Watches a 128-bit Interlaken segment stream and rebuilds packet boundaries.
// For each completed packet it reports channel, byte length and a bad flag.
// It also keeps saturating statistics and counts framing violations.
//
// Ports
//   interlaken_clock  : single clock, rising edge
//   interlaken_reset  : synchronous active-high reset
//   seg_data          : segment payload, only qualified by seg_ena (not inspected)
//   seg_chan          : channel number of the beat
//   seg_ena           : beat valid
//   seg_sop/seg_eop   : start / end of packet markers
//   seg_err           : packet error marker, meaningful with seg_eop
//   seg_mty           : empty bytes on the eop beat
//   stats_clear       : synchronous clear of counters and err_sticky
//   pkt_done          : one-cycle pulse per completed packet
//   pkt_chan/len/bad  : descriptor of the last completed packet (held)
//   pkt_cnt, byte_cnt, bad_pkt_cnt, frame_err_cnt : saturating counters
//   err_sticky        : any framing error or bad packet since last clear
module interlaken_seg_checker #(
    parameter int unsigned MAX_PKT_BYTES = 9600,
    parameter int          CNT_W         = 32
) (
    input  logic               interlaken_clock,
    input  logic               interlaken_reset,
    input  logic [127:0]       seg_data,
    input  logic [10:0]        seg_chan,
    input  logic               seg_ena,
    input  logic               seg_sop,
    input  logic               seg_eop,
    input  logic               seg_err,
    input  logic [3:0]         seg_mty,
    input  logic               stats_clear,
    output logic               pkt_done,
    output logic [10:0]        pkt_chan,
    output logic [13:0]        pkt_len,
    output logic               pkt_bad,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W+15:0]  byte_cnt,
    output logic [15:0]        bad_pkt_cnt,
    output logic [15:0]        frame_err_cnt,
    output logic               err_sticky
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] IN_PKT = 1'b1;
    localparam int         BW     = CNT_W + 16;

    // Payload content is never inspected.
    logic unused_data;
    assign unused_data = ^seg_data;

    logic [0:0]        state_q, state_d;
    logic [10:0]       chan_q, chan_d;
    logic [13:0]       len_q, len_d;
    logic              bad_q, bad_d;

    logic              pkt_done_q;
    logic [10:0]       pkt_chan_q;
    logic [13:0]       pkt_len_q;
    logic              pkt_bad_q;
    logic [CNT_W-1:0]  pkt_cnt_q;
    logic [BW-1:0]     byte_cnt_q;
    logic [15:0]       bad_cnt_q;
    logic [15:0]       frame_cnt_q;
    logic              sticky_q;

    logic [4:0]        contrib;
    logic              mty_viol;
    logic              chan_viol;
    logic [14:0]       len_sum;
    logic [13:0]       len_acc;
    logic              frame_err;
    logic              done;
    logic [10:0]       done_chan;
    logic [13:0]       done_len;
    logic              done_bad;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [BW-1:0] sat_add_bytes(input logic [BW-1:0] v,
                                                   input logic [13:0]   len);
        logic [BW:0] s;
        s = {1'b0, v} + (BW+1)'(len);
        return s[BW] ? {BW{1'b1}} : s[BW-1:0];
    endfunction

    function automatic logic over_max(input logic [13:0] len);
        return {18'd0, len} > MAX_PKT_BYTES;
    endfunction

    // A non-eop beat always carries 16 bytes; a stray mty there is ignored
    // for length and flagged as a violation instead.
    assign contrib   = seg_eop ? (5'd16 - {1'b0, seg_mty}) : 5'd16;
    assign mty_viol  = !seg_eop && (seg_mty != 4'd0);
    assign chan_viol = seg_chan != chan_q;
    assign len_sum   = {1'b0, len_q} + {10'd0, contrib};
    // Running length saturates at 16383 (bit 14 can only come from overflow).
    assign len_acc   = len_sum[14] ? 14'h3FFF : len_sum[13:0];

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        len_d     = len_q;
        bad_d     = bad_q;
        frame_err = 1'b0;
        done      = 1'b0;
        done_chan = chan_q;
        done_len  = len_acc;
        done_bad  = 1'b0;
        if (seg_ena) begin
            if (state_q == IN_PKT && !seg_sop) begin
                // Several violations on one beat still count as one error.
                frame_err = chan_viol | mty_viol;
                if (seg_eop) begin
                    done     = 1'b1;
                    done_bad = bad_q | chan_viol | seg_err | over_max(len_acc);
                    state_d  = IDLE;
                    len_d    = 14'd0;
                    bad_d    = 1'b0;
                end else begin
                    len_d = len_acc;
                    bad_d = bad_q | chan_viol | mty_viol;
                end
            end else if (seg_sop) begin
                // A sop inside an open packet drops that packet uncounted.
                frame_err = (state_q == IN_PKT) | mty_viol;
                if (seg_eop) begin
                    done      = 1'b1;
                    done_chan = seg_chan;
                    done_len  = {9'd0, contrib};
                    done_bad  = seg_err | over_max({9'd0, contrib});
                    state_d   = IDLE;
                    len_d     = 14'd0;
                    bad_d     = 1'b0;
                end else begin
                    state_d = IN_PKT;
                    chan_d  = seg_chan;
                    len_d   = 14'd16;
                    bad_d   = mty_viol;
                end
            end else begin
                // Missing sop while idle: beat is dropped.
                frame_err = 1'b1;
            end
        end
    end

    always_ff @(posedge interlaken_clock) begin
        if (interlaken_reset) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            len_q       <= '0;
            bad_q       <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_chan_q  <= '0;
            pkt_len_q   <= '0;
            pkt_bad_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            frame_cnt_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            len_q      <= len_d;
            bad_q      <= bad_d;
            pkt_done_q <= done;
            if (done) begin
                pkt_chan_q <= done_chan;
                pkt_len_q  <= done_len;
                pkt_bad_q  <= done_bad;
            end
            // Clear wins over any increment landing on the same edge.
            if (stats_clear) begin
                pkt_cnt_q   <= '0;
                byte_cnt_q  <= '0;
                bad_cnt_q   <= '0;
                frame_cnt_q <= '0;
                sticky_q    <= 1'b0;
            end else begin
                if (done) begin
                    pkt_cnt_q  <= sat_inc_cnt(pkt_cnt_q);
                    byte_cnt_q <= sat_add_bytes(byte_cnt_q, done_len);
                    if (done_bad) begin
                        bad_cnt_q <= sat_inc16(bad_cnt_q);
                    end
                end
                if (frame_err) begin
                    frame_cnt_q <= sat_inc16(frame_cnt_q);
                end
                if (frame_err || (done && done_bad)) begin
                    sticky_q <= 1'b1;
                end
            end
        end
    end

    assign pkt_done      = pkt_done_q;
    assign pkt_chan      = pkt_chan_q;
    assign pkt_len       = pkt_len_q;
    assign pkt_bad       = pkt_bad_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign byte_cnt      = byte_cnt_q;
    assign bad_pkt_cnt   = bad_cnt_q;
    assign frame_err_cnt = frame_cnt_q;
    assign err_sticky    = sticky_q;

endmodule
